// File: rtl/gray_decoder_if.sv
// gray_decoder_if: valid/ready stream bundle for the Gray decoder (Gray words in, binary words plus step status out)
interface gray_decoder_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin;
    logic             step_err;
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, gray, out_ready,
        input  in_ready, out_valid, bin, step_err, err_count
    );

    modport slave (
        input  in_valid, gray, out_ready,
        output in_ready, out_valid, bin, step_err, err_count
    );
endinterface

// File: rtl/gray_decoder.sv
// gray_decoder: registered Gray-to-binary stream stage; define GRAY_STEP_CHECK_EN to compile in the multi-bit step checker
module gray_decoder #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         rst,
    gray_decoder_if.slave bus
);
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] bin_q;
    logic             valid_q;
    logic             err_q;
    logic             accept;
    logic             illegal;

    // each binary bit is the parity of all Gray bits at and above it
    for (genvar g = 0; g < WIDTH; g++) begin : g_dec
        assign dec[g] = ^bus.gray[WIDTH-1:g];
    end

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.bin       = bin_q;
    assign bus.step_err  = err_q;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             have_prev;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0] diff;

    // more than one set bit is exactly when clearing the lowest one leaves something
    assign diff          = bus.gray ^ prev_gray;
    assign illegal       = have_prev && ((diff & (diff - WIDTH'(1))) != '0);
    assign bus.err_count = err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_gray <= '0;
            have_prev <= 1'b0;
            err_cnt   <= '0;
        end else if (accept) begin
            prev_gray <= bus.gray;
            have_prev <= 1'b1;
            if (illegal && err_cnt != '1)
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`else
    assign illegal       = 1'b0;
    assign bus.err_count = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            bin_q   <= dec;
            err_q   <= illegal;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule
